// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, drain FSM states and saturation limits for the PE column drain
package pe_pkg;
  localparam int PE_INT_BW = 5;
  localparam int PE_FRA_BW = 5;
  localparam int PE_MUL_BW = 16;
  localparam int PE_ACC_BW = 32;
  localparam int PE_COLS   = 4;
  localparam int PE_DEPTH  = 4;
  typedef enum logic {IDLE = 1'b0, CAPTURE = 1'b1} drain_state_e;
  // limits of the accumulator after the fraction bits are shifted out
  function automatic longint sat_lim(int mul_bw, bit hi);
    return hi ? (longint'(1) <<< (mul_bw - 1)) - 1 : -(longint'(1) <<< (mul_bw - 1));
  endfunction
  localparam logic [PE_MUL_BW-1:0] PE_SAT_MAX = PE_MUL_BW'(sat_lim(PE_MUL_BW, 1'b1));
  localparam logic [PE_MUL_BW-1:0] PE_SAT_MIN = PE_MUL_BW'(sat_lim(PE_MUL_BW, 1'b0));
  localparam longint PE_ACC_HI = (longint'(1) <<< (PE_MUL_BW + PE_FRA_BW - 1)) - 1;
  localparam longint PE_ACC_LO = -(longint'(1) <<< (PE_MUL_BW + PE_FRA_BW - 1));
endpackage

// File: rtl/pe_drain_fifo.sv
// pe_drain_fifo: row FIFO with valid/ready pop; a pop frees the slot for a same-cycle push when full
module pe_drain_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full      = cnt == (AW+1)'(DEPTH);
  assign pop_valid = cnt != '0;
  assign rd        = pop_valid && pop_ready;
  assign wr        = push && (!full || rd);
  assign pop_data  = mem[rp];
  // storage and pointers; contents cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) mem[wp] <= push_data;
      wp  <= wp + AW'(wr);
      rp  <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/pe_col_drain.sv
// pe_col_drain: deskews and converts bottom-PE results into rows; PE_COL_DRAIN_SAT_EN enables clamping
module pe_col_drain
  import pe_pkg::*;
#(
  parameter int INT_BW = PE_INT_BW,
  parameter int FRA_BW = PE_FRA_BW,
  parameter int MUL_BW = PE_MUL_BW,
  parameter int ACC_BW = PE_ACC_BW,
  parameter int COLS   = PE_COLS,
  parameter int DEPTH  = PE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [7:0]               len_i,
  input  logic [COLS*ACC_BW-1:0]   o_i,
  output logic                     row_valid_o,
  input  logic                     row_ready_i,
  output logic [COLS*MUL_BW-1:0]   row_data_o,
  output logic                     busy_o,
  output logic                     ovf_o,
  output logic                     sat_o
);
  localparam int SW = ACC_BW - FRA_BW;
  if (INT_BW < 1 || INT_BW + FRA_BW > ACC_BW || MUL_BW + FRA_BW > ACC_BW || COLS < 2 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("pe_col_drain: invalid parameters");
  end
  drain_state_e state;
  logic [15:0] cnt;
  logic [7:0] len_q;
  logic [COLS-1:0] clamp;
  logic [COLS*MUL_BW-1:0] row;
  logic push, drop, pop, full, sat_q, unused_bits;
  assign unused_bits = ^o_i;
  assign busy_o = state == CAPTURE;
  assign sat_o  = sat_q;
  assign push   = state == CAPTURE && cnt >= 16'(COLS - 1);
  assign pop    = row_valid_o && row_ready_i;
  assign drop   = push && full && !pop;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [MUL_BW-1:0] conv;
`ifdef PE_COL_DRAIN_SAT_EN
    localparam logic signed [SW-1:0] HI = SW'(sat_lim(MUL_BW, 1'b1));
    localparam logic signed [SW-1:0] LO = SW'(sat_lim(MUL_BW, 1'b0));
    logic signed [SW-1:0] sh;
    logic win;
    assign sh  = o_i[c*ACC_BW+FRA_BW +: SW];
    assign win = state == CAPTURE && cnt >= 16'(c) && cnt < 16'(c) + 16'(len_q);
    assign conv = sh > HI ? HI[MUL_BW-1:0] : sh < LO ? LO[MUL_BW-1:0] : sh[MUL_BW-1:0];
    assign clamp[c] = win && (sh > HI || sh < LO);
`else
    assign conv = o_i[c*ACC_BW+FRA_BW +: MUL_BW];
    assign clamp[c] = 1'b0;
`endif
    if (c == COLS - 1) begin : g_direct
      assign row[c*MUL_BW +: MUL_BW] = conv;
    end else begin : g_delay
      logic [COLS-2-c:0][MUL_BW-1:0] dl;
      // delay column c so all columns of a row line up in the same capture cycle
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dl <= '0;
        else begin
          dl[0] <= conv;
          for (int i = 1; i < COLS - 1 - c; i++) dl[i] <= dl[i-1];
        end
      assign row[c*MUL_BW +: MUL_BW] = dl[COLS-2-c];
    end
  end
  // capture sequencing: accept a start in IDLE, run len+COLS-1 cycles, keep sticky flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      ovf_o <= 1'b0;
      sat_q <= 1'b0;
    end else if (state == IDLE) begin
      if (start_i && len_i != 8'd0) begin
        state <= CAPTURE;
        cnt   <= '0;
        len_q <= len_i;
        ovf_o <= 1'b0;
        sat_q <= 1'b0;
      end
    end else begin
      cnt   <= cnt + 16'd1;
      state <= cnt == 16'(len_q) + 16'(COLS - 2) ? IDLE : CAPTURE;
      ovf_o <= ovf_o | drop;
      sat_q <= sat_q | (|clamp);
    end
  pe_drain_fifo #(.W(COLS*MUL_BW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (row),
    .full      (full),
    .pop_valid (row_valid_o),
    .pop_ready (row_ready_i),
    .pop_data  (row_data_o)
  );
endmodule

// File: doc/pe_col_drain.md
PE_COL_DRAIN -- requirements
Module: pe_col_drain

Interface
REQ-001 SHALL have parameters: INT_BW 5 (integer bits of result); FRA_BW 5 (fraction bits dropped on conversion); MUL_BW 16 (output word width); ACC_BW 32 (accumulator width); COLS 4 (array columns); DEPTH 4 (row FIFO entries, power of 2).
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have ports: start_i in 1 capture start pulse; len_i in 8 result rows per capture, 1..255; o_i in COLS*ACC_BW bottom-PE accumulator outputs, column c at bits [c*ACC_BW +: ACC_BW].
REQ-004 SHALL have ports: row_valid_o out 1; row_ready_i in 1; row_data_o out COLS*MUL_BW deskewed converted row, column c at [c*MUL_BW +: MUL_BW].
REQ-005 SHALL have ports: busy_o out 1 capture in progress; ovf_o out 1 sticky row-drop flag; sat_o out 1 sticky saturation flag.

Function
REQ-006 SHALL implement FSM IDLE, CAPTURE; IDLE->CAPTURE on start_i; CAPTURE->IDLE after capture cycle len+COLS-2; busy_o = (state==CAPTURE).
REQ-007 SHALL latch len_i on start_i in IDLE; start_i and len_i SHALL be ignored in CAPTURE; start_i with len_i=0 SHALL be ignored.
REQ-008 SHALL number capture cycles from 0, cycle 0 being the first cycle after start_i; column c result k SHALL be sampled in capture cycle k+c.
REQ-009 SHALL delay column c samples by COLS-1-c cycles so row k is complete in capture cycle k+COLS-1 and pushed into the FIFO at that cycle's clock edge.
REQ-010 SHALL convert each sample: o > 2^(MUL_BW+FRA_BW-1)-1 -> 0x7FFF-pattern (0 then ones); o < -2^(MUL_BW+FRA_BW-1) -> 0x8000-pattern (1 then zeros); else o[FRA_BW+MUL_BW-1 : FRA_BW].
REQ-011 SHALL present FIFO head on row_data_o with row_valid_o high while non-empty; pop on row_valid_o && row_ready_i; row_data_o stable while valid && !ready.
REQ-012 SHALL allow push and pop in the same cycle when full (pop frees slot, row accepted).
REQ-013 SHALL, when a row completes with FIFO full and no pop that cycle, drop the row and set ovf_o.
REQ-014 SHALL clear ovf_o and sat_o on an accepted start_i; FIFO contents SHALL be preserved across start.
REQ-015 SHALL give first-row latency: row 0 visible on row_valid_o in the cycle after capture cycle COLS-1.

Reset
REQ-016 SHALL on rst_n low, at any time including mid-capture: state IDLE, FIFO empty, delay lines zero; busy_o, row_valid_o, ovf_o, sat_o 0; row_data_o 0.

Configuration
REQ-017 SHALL with PE_COL_DRAIN_SAT_EN defined apply REQ-010 clamping and set sat_o whenever any sample clamps.
REQ-018 SHALL without PE_COL_DRAIN_SAT_EN output o[FRA_BW+MUL_BW-1 : FRA_BW] unconditionally (wrap) and tie sat_o to 0.

Structure
REQ-019 SHALL place in shared package pe_pkg: width defaults, drain state enum, saturation max/min constants derived from MUL_BW and FRA_BW.
REQ-020 SHALL instantiate one sub-module pe_drain_fifo (parameterised width/depth, valid/ready pop, full/empty).

Verification
REQ-021 SHALL cover: start len=1, all o_i=64 at skewed cycles -> one row, all columns 0x0002, row_valid_o at capture cycle 4.
REQ-022 SHALL cover: o_i col0 = 0x00200000, col1 = -64 -> SAT_EN: 0x7FFF, 0xFFFE, sat_o=1; no macro: 0x0000, 0xFFFE, sat_o=0.
REQ-023 SHALL cover: len=6, row_ready_i held 0 -> rows 0..3 stored, rows 4,5 dropped, ovf_o=1; then drain -> rows 0..3 in order.
REQ-024 SHALL cover: FIFO full, row_ready_i=1 on the cycle row 4 completes -> no drop, ovf_o=0.
REQ-025 SHALL cover: rst_n low during capture cycle 3 of len=8 -> all outputs 0, FIFO empty; subsequent start len=2 yields exactly 2 correct rows.
REQ-026 SHALL cover: start_i pulsed during CAPTURE -> ignored, row count equals first len.
